// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD fill path: arbiter FSM encoding,
// RGB888 colour constants and default frame geometry.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCheck    = 3'd1,
        StLaunch   = 3'd2,
        StWaitDone = 3'd3,
        StRelease  = 3'd4
    } arb_state_e;

    localparam int unsigned OwnerW       = 3;
    localparam int unsigned HDispDefault = 1024;
    localparam int unsigned VDispDefault = 600;

    localparam logic [23:0] RgbBlack = 24'h000000;
    localparam logic [23:0] RgbWhite = 24'hFFFFFF;
    localparam logic [23:0] RgbRed   = 24'hFF0000;
    localparam logic [23:0] RgbGreen = 24'h00FF00;
    localparam logic [23:0] RgbBlue  = 24'h0000FF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ; returns one-hot grant plus its index.
module rr_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OwnerW-1:0]  rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OwnerW-1:0]  gnt_idx,
    output logic               gnt_valid
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IdxW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = OwnerW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_fill_arbiter.sv
// Round-robin front end for the shared LCD fill engine: grants one client,
// bounds-checks its command, runs the enable/busy handshake and reports ack/err.
module lcd_fill_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned H_DISP   = HDispDefault,
    parameter int unsigned V_DISP   = VDispDefault,
    parameter int unsigned START_TO = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_ready,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_x,
    input  logic [16*NUM_REQ-1:0]   req_y,
    input  logic [24*NUM_REQ-1:0]   req_pixel,
    input  logic [24*NUM_REQ-1:0]   req_len,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      err,
    output logic                    eng_enable,
    output logic [15:0]             eng_x,
    output logic [15:0]             eng_y,
    output logic [23:0]             eng_pixel,
    output logic [23:0]             eng_len,
    input  logic                    eng_busy,
    output logic [OwnerW-1:0]       owner,
    output logic                    active
);

    localparam int unsigned      WdW    = $clog2(START_TO + 1);
    localparam logic [WdW-1:0]   WdLast = WdW'(START_TO - 1);
    localparam logic [WdW-1:0]   WdMax  = WdW'(START_TO);
    localparam logic [15:0]      HLim   = 16'(H_DISP);
    localparam logic [15:0]      VLim   = 16'(V_DISP);

    arb_state_e          state;
    logic [OwnerW-1:0]   rr_ptr;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [WdW-1:0]      wd_cnt;

    logic [NUM_REQ-1:0]  gnt;
    logic [OwnerW-1:0]   gnt_idx;
    logic                gnt_valid;

    logic [15:0]         sel_x;
    logic [15:0]         sel_y;
    logic [23:0]         sel_pixel;
    logic [23:0]         sel_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // One-hot mux of the winning client's command fields.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_pixel = '0;
        sel_len   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x     = req_x[16*i +: 16];
                sel_y     = req_y[16*i +: 16];
                sel_pixel = req_pixel[24*i +: 24];
                sel_len   = req_len[24*i +: 24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            owner      <= '0;
            owner_oh   <= '0;
            active     <= 1'b0;
            ack        <= '0;
            err        <= '0;
            eng_enable <= 1'b0;
            eng_x      <= '0;
            eng_y      <= '0;
            eng_pixel  <= '0;
            eng_len    <= '0;
            wd_cnt     <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            unique case (state)
                StIdle: begin
                    // A stale busy from the engine blocks new grants.
                    if (mem_ready && gnt_valid && !eng_busy) begin
                        eng_x     <= sel_x;
                        eng_y     <= sel_y;
                        eng_pixel <= sel_pixel;
                        eng_len   <= sel_len;
                        owner     <= gnt_idx;
                        owner_oh  <= gnt;
                        active    <= 1'b1;
                        state     <= StCheck;
                    end
                end
                StCheck: begin
                    if (eng_x >= HLim || eng_y >= VLim || eng_len == '0) begin
                        err   <= owner_oh;
                        state <= StRelease;
                    end else begin
                        eng_enable <= 1'b1;
                        wd_cnt     <= '0;
                        state      <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (eng_busy) begin
                        eng_enable <= 1'b0;
                        state      <= StWaitDone;
                    end else if (wd_cnt >= WdLast) begin
                        eng_enable <= 1'b0;
                        err        <= owner_oh;
                        state      <= StRelease;
                    end else if (wd_cnt != WdMax) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!eng_busy) begin
                        ack   <= owner_oh;
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    active <= 1'b0;
                    rr_ptr <= (owner == OwnerW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fill_arbiter.sv
// Directed bench for lcd_fill_arbiter with a simple fill-engine model.
module tb_lcd_fill_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_ready;
    logic [3:0]   req;
    logic [63:0]  req_x;
    logic [63:0]  req_y;
    logic [95:0]  req_pixel;
    logic [95:0]  req_len;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic         eng_enable;
    logic [15:0]  eng_x;
    logic [15:0]  eng_y;
    logic [23:0]  eng_pixel;
    logic [23:0]  eng_len;
    logic         eng_busy;
    logic [2:0]   owner;
    logic         active;

    int n_cmp  = 0;
    int n_fail = 0;

    // Engine model: raises busy one cycle after seeing enable, holds it
    // busy_len cycles; never responds while dead is set.
    int   busy_len = 120;
    int   busy_cnt = 0;
    logic dead     = 1'b0;

    lcd_fill_arbiter #(
        .NUM_REQ  (4),
        .H_DISP   (1024),
        .V_DISP   (600),
        .START_TO (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_ready  (mem_ready),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_pixel  (req_pixel),
        .req_len    (req_len),
        .ack        (ack),
        .err        (err),
        .eng_enable (eng_enable),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_pixel  (eng_pixel),
        .eng_len    (eng_len),
        .eng_busy   (eng_busy),
        .owner      (owner),
        .active     (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            busy_cnt <= 0;
        end else if (eng_busy) begin
            if (busy_cnt <= 1) eng_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (eng_enable && !dead) begin
            eng_busy <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int c, input logic [15:0] x, input logic [15:0] y,
                           input logic [23:0] len, input logic [23:0] pix);
        req_x[16*c +: 16]     = x;
        req_y[16*c +: 16]     = y;
        req_len[24*c +: 24]   = len;
        req_pixel[24*c +: 24] = pix;
    endtask

    // Bounded wait for the next ack or err pulse.
    task automatic wait_done();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ((ack | err) != 4'b0) break;
        end
    endtask

    task automatic reject(input int c, input logic [15:0] x, input logic [15:0] y,
                          input logic [23:0] len, input string tag);
        set_cmd(c, x, y, len, 24'h123456);
        req = 4'(1 << c);
        tick();
        check({tag, "_active"}, 32'(active), 32'd1);
        tick();
        check({tag, "_err"}, 32'(err), 32'(1 << c));
        check({tag, "_noen"}, 32'(eng_enable), 32'd0);
        check({tag, "_noack"}, 32'(ack), 32'd0);
        req = 4'b0;
        tick();
        check({tag, "_errclr"}, 32'(err), 32'd0);
        check({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        int n_hi;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        req       = '0;
        req_x     = '0;
        req_y     = '0;
        req_pixel = '0;
        req_len   = '0;
        tick();
        tick();
        check("rst_enable", 32'(eng_enable), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_ackerr", 32'({ack, err}), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_eng_x", 32'(eng_x), 32'd0);
        check("rst_eng_len", 32'(eng_len), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1) single command, grant/check latency and capture
        set_cmd(0, 16'd10, 16'd20, 24'd100, 24'h00FF00);
        req = 4'b0001;
        tick();
        check("t1_active", 32'(active), 32'd1);
        check("t1_en_early", 32'(eng_enable), 32'd0);
        tick();
        check("t1_enable", 32'(eng_enable), 32'd1);
        check("t1_x", 32'(eng_x), 32'd10);
        check("t1_y", 32'(eng_y), 32'd20);
        check("t1_len", 32'(eng_len), 32'd100);
        check("t1_pixel", 32'(eng_pixel), 32'h00FF00);
        set_cmd(0, 16'd999, 16'd999, 24'd7, 24'h0000FF);
        wait_done();
        check("t1_ack", 32'(ack), 32'b0001);
        check("t1_noerr", 32'(err), 32'd0);
        check("t1_x_stable", 32'(eng_x), 32'd10);
        req = 4'b0;
        tick();
        check("t1_ack_pulse", 32'(ack), 32'd0);
        check("t1_active_fall", 32'(active), 32'd0);

        // 2) round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        busy_len = 5;
        for (int c = 0; c < 4; c++) set_cmd(c, 16'(100 + c), 16'd1, 24'd1, 24'h0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done();
            check("t2_ack", 32'(ack), 32'(1) << (k % 4));
            check("t2_owner", 32'(owner), 32'(k % 4));
            check("t2_x", 32'(eng_x), 32'(100 + k % 4));
            req = req & ~ack;
            tick();
            if (k < 4) req = 4'b1111;
        end
        req = 4'b0;

        // 3) bounds rejections (rr_ptr now 1)
        reject(2, 16'd1024, 16'd0, 24'd5, "t3_x");
        reject(1, 16'd0, 16'd600, 24'd1, "t3_y");
        reject(3, 16'd1023, 16'd599, 24'd0, "t3_len");

        // 4) engine never answers; boundary command accepted then aborted
        dead = 1'b1;
        set_cmd(1, 16'd1023, 16'd599, 24'd1, 24'hFF0000);
        set_cmd(2, 16'd5, 16'd5, 24'd7, 24'h0000FF);
        req = 4'b0110;
        tick();
        tick();
        check("t4_enable", 32'(eng_enable), 32'd1);
        check("t4_owner", 32'(owner), 32'd1);
        n_hi = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!eng_enable) break;
            n_hi++;
        end
        check("t4_en_cycles", 32'(n_hi), 32'd64);
        check("t4_err", 32'(err), 32'b0010);
        check("t4_noack", 32'(ack), 32'd0);
        dead = 1'b0;
        req  = 4'b0100;
        wait_done();
        check("t4_next_ack", 32'(ack), 32'b0100);
        req = 4'b0;
        tick();

        // 5) mem_ready gating
        mem_ready = 1'b0;
        set_cmd(1, 16'd3, 16'd4, 24'd2, 24'h00FF00);
        req = 4'b0010;
        repeat (5) tick();
        check("t5_nogrant", 32'(active), 32'd0);
        check("t5_owner_kept", 32'(owner), 32'd2);
        mem_ready = 1'b1;
        tick();
        check("t5_grant", 32'(active), 32'd1);
        check("t5_owner", 32'(owner), 32'd1);
        wait_done();
        check("t5_ack", 32'(ack), 32'b0010);
        req = 4'b0;
        tick();

        // 6) async reset in WAIT_DONE
        busy_len = 50;
        set_cmd(2, 16'd8, 16'd9, 24'd10, 24'hFFFFFF);
        req = 4'b0100;
        repeat (10) tick();
        check("t6_waiting", 32'({active, eng_enable, eng_busy}), 32'b101);
        rst_n = 1'b0;
        req   = 4'b0;
        #1;
        check("t6_rst_enable", 32'(eng_enable), 32'd0);
        check("t6_rst_active", 32'(active), 32'd0);
        check("t6_rst_ackerr", 32'({ack, err}), 32'd0);
        check("t6_rst_owner", 32'(owner), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        set_cmd(3, 16'd1, 16'd2, 24'd3, 24'h0000FF);
        req = 4'b1000;
        tick();
        check("t6_grant", 32'(active), 32'd1);
        check("t6_owner", 32'(owner), 32'd3);
        tick();
        check("t6_enable", 32'(eng_enable), 32'd1);
        wait_done();
        check("t6_ack", 32'(ack), 32'b1000);
        req = 4'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
